// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 4:1 mux and its round-robin select generator.
// mux41 imports N_IN/SEL_W from here as well.
package mux_pkg;

    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_IN-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_IN-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux41.sv
// Plain 4:1 data mux fed by the round-robin select generator.
module mux41
    import mux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [N_IN-1:0][W-1:0] i,
    input  logic [SEL_W-1:0]       s,
    output logic [W-1:0]           y
);

    assign y = i[s];

endmodule

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request after 'last', wrapping,
// with an optional mask that removes one index (normally the current holder).
module rr_pick4
    import mux_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] last,
    input  logic             mask_en,
    input  logic [SEL_W-1:0] mask_idx,
    output logic             any,
    output logic [SEL_W-1:0] w
);

    logic [N_IN-1:0]  cand;
    logic [SEL_W-1:0] idx;

    always_comb begin
        cand = req;
        if (mask_en) begin
            cand[mask_idx] = 1'b0;
        end
    end

    // Offset N_IN wraps to 'last' itself, so the previous holder is scanned last.
    always_comb begin
        any = 1'b0;
        w   = last;
        idx = last;
        for (int k = 1; k <= N_IN; k++) begin
            idx = last + SEL_W'(k);
            if (!any && cand[idx]) begin
                any = 1'b1;
                w   = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sel.sv
// Round-robin select generator for mux41: grants one requester for a burst of up to
// BURST_MAX accepted transfers, with registered sel/grant so the mux output is stable per beat.
//
// state | meaning
// IDLE  | no grant held; grant=0, sel keeps its last value
// GRANT | sel/grant point at one requester; cnt counts accepted beats of the burst
module rr_mux_sel
    import mux_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_IN-1:0]  grant,
    output logic             sel_valid,
    output logic             burst_end
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t            state, state_nx;
    logic [SEL_W-1:0]  sel_nx;
    logic [N_IN-1:0]   grant_nx;
    logic [SEL_W-1:0]  last, last_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              burst_end_nx;

    logic              xfer;
    logic              hit_limit;
    logic              dropped;
    logic              release_now;
    logic [SEL_W-1:0]  pick_last;
    logic              pick_any;
    logic [SEL_W-1:0]  pick_w;

    assign sel_valid   = (state == GRANT) && req[sel];
    assign xfer        = sel_valid && out_ready;
    assign hit_limit   = xfer && (cnt == CNT_LAST);
    assign dropped     = (state == GRANT) && !req[sel];
    assign release_now = hit_limit || dropped;

    // On release 'last' becomes sel, so the pick must already rotate from sel this cycle.
    assign pick_last = (state == GRANT) ? sel : last;

    rr_pick4 u_pick (
        .req      (req),
        .last     (pick_last),
        .mask_en  (hit_limit),
        .mask_idx (sel),
        .any      (pick_any),
        .w        (pick_w)
    );

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        grant_nx     = grant;
        cnt_nx       = cnt;
        last_nx      = last;
        burst_end_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    sel_nx   = pick_w;
                    grant_nx = sel_to_onehot(pick_w);
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_nx      = sel;
                    burst_end_nx = 1'b1;
                    cnt_nx       = '0;
                    if (pick_any) begin
                        sel_nx   = pick_w;
                        grant_nx = sel_to_onehot(pick_w);
                    end else if (hit_limit && req[sel]) begin
                        // Sole requester at its burst limit: keep it, fresh burst.
                        sel_nx   = sel;
                        grant_nx = grant;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                    end
                end else if (xfer) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            grant     <= '0;
            last      <= SEL_W'(N_IN - 1);
            cnt       <= '0;
            burst_end <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            grant     <= grant_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            burst_end <= burst_end_nx;
        end
    end

endmodule
